// File: rtl/ysyx_22050019_pkg.sv
// Shared constants for the write-back / register-file slice.
// No ports: parameters for datapath width, register indexing and the
// instruction encoding that halts the core on commit.
package ysyx_22050019_pkg;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned NREG   = 32;

  localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

  localparam logic [REG_AW-1:0] X0_IDX = REG_AW'(0);
  localparam logic [REG_AW-1:0] A0_IDX = REG_AW'(10);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } halt_state_e;

endpackage

// File: rtl/ysyx_22050019_wb_regfile_if.sv
// Bus bundle between MEM/WB, ID and the write-back register file.
// Write port: wb_we_i / wb_waddr_i / wb_wdata_i.
// Commit:     commit_i / commit_pc_i / commit_inst_i.
// Read ports: raddr1_i, raddr2_i -> rdata1_o, rdata2_o (combinational).
// Status:     retire_cnt_o, last_pc_o, a0_o, halt_o.
// master drives the *_i signals, slave (the register file) drives *_o.
interface ysyx_22050019_wb_regfile_if
  import ysyx_22050019_pkg::*;
();

  logic              wb_we_i;
  logic [REG_AW-1:0] wb_waddr_i;
  logic [XLEN-1:0]   wb_wdata_i;
  logic              commit_i;
  logic [XLEN-1:0]   commit_pc_i;
  logic [31:0]       commit_inst_i;
  logic [REG_AW-1:0] raddr1_i;
  logic [REG_AW-1:0] raddr2_i;
  logic [XLEN-1:0]   rdata1_o;
  logic [XLEN-1:0]   rdata2_o;
  logic [XLEN-1:0]   retire_cnt_o;
  logic [XLEN-1:0]   last_pc_o;
  logic [XLEN-1:0]   a0_o;
  logic              halt_o;

  modport master (
    output wb_we_i, wb_waddr_i, wb_wdata_i,
    output commit_i, commit_pc_i, commit_inst_i,
    output raddr1_i, raddr2_i,
    input  rdata1_o, rdata2_o, retire_cnt_o, last_pc_o, a0_o, halt_o
  );

  modport slave (
    input  wb_we_i, wb_waddr_i, wb_wdata_i,
    input  commit_i, commit_pc_i, commit_inst_i,
    input  raddr1_i, raddr2_i,
    output rdata1_o, rdata2_o, retire_cnt_o, last_pc_o, a0_o, halt_o
  );

endinterface

// File: rtl/ysyx_22050019_regfile_bank.sv
// Register storage: NREG x XLEN array, one write port, two raw read
// ports and a dedicated a0 tap. No bypass and no x0 masking here; the
// caller gates the write enable and masks index 0 on the read side.
// Ports: clk, rst_n (sync, active-low, clears all entries),
//        we_i/waddr_i/wdata_i, raddr1_i/raddr2_i -> rdata1_o/rdata2_o,
//        a0_o = stored x10.
module ysyx_22050019_regfile_bank
  import ysyx_22050019_pkg::*;
#(
  parameter int unsigned W  = XLEN,
  parameter int unsigned N  = NREG,
  parameter int unsigned AW = REG_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr1_i,
  input  logic [AW-1:0] raddr2_i,
  output logic [W-1:0]  rdata1_o,
  output logic [W-1:0]  rdata2_o,
  output logic [W-1:0]  a0_o
);

  logic [W-1:0] regs_q [N];
  logic [W-1:0] regs_d [N];

  always_comb begin
    regs_d = regs_q;
    if (we_i) regs_d[waddr_i] = wdata_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    rdata1_o = regs_q[raddr1_i];
    rdata2_o = regs_q[raddr2_i];
    a0_o     = regs_q[A0_IDX];
  end

endmodule

// File: rtl/ysyx_22050019_wb_regfile.sv
// Write-back stage register file with difftest bookkeeping.
// Ports: clk, rst_n (sync, active-low), bus (slave side of
// ysyx_22050019_wb_regfile_if): write port, commit info, two bypassed
// combinational read ports, retire counter, last committed PC, a0 and
// a sticky halt that sets the cycle after an ebreak commits.
module ysyx_22050019_wb_regfile
  import ysyx_22050019_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  ysyx_22050019_wb_regfile_if.slave bus
);

  halt_state_e     state_q, state_d;
  logic [XLEN-1:0] retire_cnt_q, retire_cnt_d;
  logic [XLEN-1:0] last_pc_q, last_pc_d;
  logic            wr_en, cm_en;
  logic [XLEN-1:0] raw1, raw2, raw_a0;

  // Enables use the pre-edge state, so a write alongside the ebreak lands.
  always_comb begin
    wr_en = bus.wb_we_i && (bus.wb_waddr_i != X0_IDX) && (state_q == ST_RUN);
    cm_en = bus.commit_i && (state_q == ST_RUN);
  end

  ysyx_22050019_regfile_bank #(
    .W  (XLEN),
    .N  (NREG),
    .AW (REG_AW)
  ) u_bank (
    .clk      (clk),
    .rst_n    (rst_n),
    .we_i     (wr_en),
    .waddr_i  (bus.wb_waddr_i),
    .wdata_i  (bus.wb_wdata_i),
    .raddr1_i (bus.raddr1_i),
    .raddr2_i (bus.raddr2_i),
    .rdata1_o (raw1),
    .rdata2_o (raw2),
    .a0_o     (raw_a0)
  );

  always_comb begin
    retire_cnt_d = retire_cnt_q;
    last_pc_d    = last_pc_q;
    state_d      = state_q;
    if (cm_en) begin
      retire_cnt_d = retire_cnt_q + XLEN'(1);
      last_pc_d    = bus.commit_pc_i;
      if (bus.commit_inst_i == EBREAK_INST) state_d = ST_HALTED;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      retire_cnt_q <= '0;
      last_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      retire_cnt_q <= retire_cnt_d;
      last_pc_q    <= last_pc_d;
    end
  end

  // wr_en already excludes x0 and the halted state, so the bypass never
  // fires in either case.
  always_comb begin
    if (bus.raddr1_i == X0_IDX)                         bus.rdata1_o = '0;
    else if (wr_en && (bus.raddr1_i == bus.wb_waddr_i)) bus.rdata1_o = bus.wb_wdata_i;
    else                                                bus.rdata1_o = raw1;

    if (bus.raddr2_i == X0_IDX)                         bus.rdata2_o = '0;
    else if (wr_en && (bus.raddr2_i == bus.wb_waddr_i)) bus.rdata2_o = bus.wb_wdata_i;
    else                                                bus.rdata2_o = raw2;

    bus.retire_cnt_o = retire_cnt_q;
    bus.last_pc_o    = last_pc_q;
    bus.a0_o         = raw_a0;
    bus.halt_o       = (state_q == ST_HALTED);
  end

endmodule

// File: tb/tb_ysyx_22050019_wb_regfile.sv
module tb_ysyx_22050019_wb_regfile;
  import ysyx_22050019_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  ysyx_22050019_wb_regfile_if bus ();

  ysyx_22050019_wb_regfile dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change just after a falling edge; the following rising edge
  // captures them and results are checked at the next falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.wb_we_i       = 1'b0;
    bus.wb_waddr_i    = '0;
    bus.wb_wdata_i    = '0;
    bus.commit_i      = 1'b0;
    bus.commit_pc_i   = '0;
    bus.commit_inst_i = 32'h0000_0013;
    bus.raddr1_i      = '0;
    bus.raddr2_i      = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.retire_cnt_o !== 64'd0) begin
      failures++; $display("FAIL reset_retire_cnt got=%h exp=0", bus.retire_cnt_o);
    end
    checks++;
    if (bus.last_pc_o !== 64'd0) begin
      failures++; $display("FAIL reset_last_pc got=%h exp=0", bus.last_pc_o);
    end
    checks++;
    if (bus.halt_o !== 1'b0) begin
      failures++; $display("FAIL reset_halt got=%b exp=0", bus.halt_o);
    end
    checks++;
    if (bus.a0_o !== 64'd0) begin
      failures++; $display("FAIL reset_a0 got=%h exp=0", bus.a0_o);
    end
    for (int i = 0; i < 32; i++) begin
      bus.raddr1_i = 5'(i);
      bus.raddr2_i = 5'(31 - i);
      #1;
      checks++;
      if (bus.rdata1_o !== 64'd0 || bus.rdata2_o !== 64'd0) begin
        failures++;
        $display("FAIL reset_reg idx=%0d got1=%h got2=%h exp=0", i, bus.rdata1_o, bus.rdata2_o);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_write_read();
    bus.wb_we_i    = 1'b1;
    bus.wb_waddr_i = 5'd5;
    bus.wb_wdata_i = 64'h1234_5678_9ABC_DEF0;
    step();
    bus.wb_we_i  = 1'b0;
    bus.raddr1_i = 5'd5;
    #1;
    checks++;
    if (bus.rdata1_o !== 64'h1234_5678_9ABC_DEF0) begin
      failures++; $display("FAIL write_read_x5 got=%h exp=123456789abcdef0", bus.rdata1_o);
    end
    for (int i = 0; i < 32; i++) begin
      if (i != 5) begin
        bus.raddr2_i = 5'(i);
        #1;
        checks++;
        if (bus.rdata2_o !== 64'd0) begin
          failures++; $display("FAIL write_read_other idx=%0d got=%h exp=0", i, bus.rdata2_o);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_bypass();
    bus.wb_we_i    = 1'b1;
    bus.wb_waddr_i = 5'd7;
    bus.wb_wdata_i = 64'hAA;
    bus.raddr1_i   = 5'd7;
    bus.raddr2_i   = 5'd7;
    #1;
    checks++;
    if (bus.rdata1_o !== 64'hAA || bus.rdata2_o !== 64'hAA) begin
      failures++; $display("FAIL bypass_same_cycle got1=%h got2=%h exp=aa", bus.rdata1_o, bus.rdata2_o);
    end
    // a different index on port 2 must not see the bypass
    bus.raddr2_i = 5'd5;
    #1;
    checks++;
    if (bus.rdata2_o !== 64'h1234_5678_9ABC_DEF0) begin
      failures++; $display("FAIL bypass_other_port got=%h exp=123456789abcdef0", bus.rdata2_o);
    end
    bus.raddr2_i = 5'd7;
    step();
    bus.wb_we_i = 1'b0;
    #1;
    checks++;
    if (bus.rdata1_o !== 64'hAA || bus.rdata2_o !== 64'hAA) begin
      failures++; $display("FAIL bypass_stored got1=%h got2=%h exp=aa", bus.rdata1_o, bus.rdata2_o);
    end
  endtask

  task automatic test_x0();
    bus.wb_we_i    = 1'b1;
    bus.wb_waddr_i = 5'd0;
    bus.wb_wdata_i = 64'hFFFF;
    bus.raddr1_i   = 5'd0;
    bus.raddr2_i   = 5'd0;
    #1;
    checks++;
    if (bus.rdata1_o !== 64'd0 || bus.rdata2_o !== 64'd0) begin
      failures++; $display("FAIL x0_same_cycle got1=%h got2=%h exp=0", bus.rdata1_o, bus.rdata2_o);
    end
    step();
    bus.wb_we_i = 1'b0;
    #1;
    checks++;
    if (bus.rdata1_o !== 64'd0 || bus.rdata2_o !== 64'd0) begin
      failures++; $display("FAIL x0_next_cycle got1=%h got2=%h exp=0", bus.rdata1_o, bus.rdata2_o);
    end
  endtask

  task automatic test_back_to_back();
    bus.wb_we_i    = 1'b1;
    bus.wb_waddr_i = 5'd1;
    bus.wb_wdata_i = 64'h1111;
    step();
    bus.wb_waddr_i = 5'd2;
    bus.wb_wdata_i = 64'h2222;
    bus.raddr1_i   = 5'd1;
    bus.raddr2_i   = 5'd2;
    #1;
    checks++;
    if (bus.rdata1_o !== 64'h1111 || bus.rdata2_o !== 64'h2222) begin
      failures++; $display("FAIL b2b_mixed got1=%h got2=%h exp=1111/2222", bus.rdata1_o, bus.rdata2_o);
    end
    step();
    bus.wb_we_i = 1'b0;
    #1;
    checks++;
    if (bus.rdata1_o !== 64'h1111 || bus.rdata2_o !== 64'h2222) begin
      failures++; $display("FAIL b2b_stored got1=%h got2=%h exp=1111/2222", bus.rdata1_o, bus.rdata2_o);
    end
  endtask

  task automatic test_commit();
    bus.commit_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.commit_pc_i = 64'h8000_0000 + 64'(4 * i);
      step();
    end
    bus.commit_i = 1'b0;
    checks++;
    if (bus.retire_cnt_o !== 64'd3) begin
      failures++; $display("FAIL commit_cnt got=%0d exp=3", bus.retire_cnt_o);
    end
    checks++;
    if (bus.last_pc_o !== 64'h8000_0008) begin
      failures++; $display("FAIL commit_last_pc got=%h exp=80000008", bus.last_pc_o);
    end
    checks++;
    if (bus.halt_o !== 1'b0) begin
      failures++; $display("FAIL commit_halt got=%b exp=0", bus.halt_o);
    end
  endtask

  task automatic test_ebreak();
    // a0 is unbypassed: the write to x10 only shows after the edge
    bus.wb_we_i    = 1'b1;
    bus.wb_waddr_i = 5'd10;
    bus.wb_wdata_i = 64'h2A;
    #1;
    checks++;
    if (bus.a0_o !== 64'd0) begin
      failures++; $display("FAIL a0_no_bypass got=%h exp=0", bus.a0_o);
    end
    step();
    checks++;
    if (bus.a0_o !== 64'h2A) begin
      failures++; $display("FAIL a0_written got=%h exp=2a", bus.a0_o);
    end
    bus.wb_wdata_i = 64'd0;
    step();
    // ebreak commit with a simultaneous write to x3
    bus.wb_waddr_i    = 5'd3;
    bus.wb_wdata_i    = 64'd9;
    bus.commit_i      = 1'b1;
    bus.commit_pc_i   = 64'h8000_000C;
    bus.commit_inst_i = EBREAK_INST;
    #1;
    checks++;
    if (bus.halt_o !== 1'b0) begin
      failures++; $display("FAIL ebreak_halt_early got=%b exp=0", bus.halt_o);
    end
    step();
    bus.wb_we_i       = 1'b0;
    bus.commit_i      = 1'b0;
    bus.commit_inst_i = 32'h0000_0013;
    bus.raddr1_i      = 5'd3;
    #1;
    checks++;
    if (bus.halt_o !== 1'b1) begin
      failures++; $display("FAIL ebreak_halt got=%b exp=1", bus.halt_o);
    end
    checks++;
    if (bus.retire_cnt_o !== 64'd4 || bus.last_pc_o !== 64'h8000_000C) begin
      failures++; $display("FAIL ebreak_counted cnt=%0d pc=%h exp=4/8000000c", bus.retire_cnt_o, bus.last_pc_o);
    end
    checks++;
    if (bus.rdata1_o !== 64'd9 || bus.a0_o !== 64'd0) begin
      failures++; $display("FAIL ebreak_write x3=%h a0=%h exp=9/0", bus.rdata1_o, bus.a0_o);
    end
    // halted: writes, commits and bypass are all suppressed
    bus.wb_we_i     = 1'b1;
    bus.wb_waddr_i  = 5'd3;
    bus.wb_wdata_i  = 64'd1;
    bus.commit_i    = 1'b1;
    bus.commit_pc_i = 64'h8000_0010;
    #1;
    checks++;
    if (bus.rdata1_o !== 64'd9) begin
      failures++; $display("FAIL halted_no_bypass got=%h exp=9", bus.rdata1_o);
    end
    step();
    step();
    bus.wb_we_i  = 1'b0;
    bus.commit_i = 1'b0;
    #1;
    checks++;
    if (bus.rdata1_o !== 64'd9 || bus.retire_cnt_o !== 64'd4 ||
        bus.last_pc_o !== 64'h8000_000C || bus.halt_o !== 1'b1) begin
      failures++;
      $display("FAIL halted_frozen x3=%h cnt=%0d pc=%h halt=%b exp=9/4/8000000c/1",
               bus.rdata1_o, bus.retire_cnt_o, bus.last_pc_o, bus.halt_o);
    end
    @(negedge clk);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.rdata1_o !== 64'd0 || bus.retire_cnt_o !== 64'd0 ||
        bus.last_pc_o !== 64'd0 || bus.halt_o !== 1'b0) begin
      failures++;
      $display("FAIL halt_reset x3=%h cnt=%0d pc=%h halt=%b exp=0/0/0/0",
               bus.rdata1_o, bus.retire_cnt_o, bus.last_pc_o, bus.halt_o);
    end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    force dut.retire_cnt_q = '1;
    #1;
    checks++;
    if (bus.retire_cnt_o !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      failures++; $display("FAIL wrap_preload got=%h exp=ffffffffffffffff", bus.retire_cnt_o);
    end
    release dut.retire_cnt_q;
    bus.commit_i    = 1'b1;
    bus.commit_pc_i = 64'h8000_0100;
    step();
    bus.commit_i = 1'b0;
    checks++;
    if (bus.retire_cnt_o !== 64'd0 || bus.last_pc_o !== 64'h8000_0100) begin
      failures++; $display("FAIL wrap_cnt cnt=%h pc=%h exp=0/80000100", bus.retire_cnt_o, bus.last_pc_o);
    end
  endtask

  task automatic test_reset_wins();
    bus.wb_we_i     = 1'b1;
    bus.wb_waddr_i  = 5'd12;
    bus.wb_wdata_i  = 64'h77;
    bus.commit_i    = 1'b1;
    bus.commit_pc_i = 64'h8000_0200;
    rst_n           = 1'b0;
    step();
    rst_n        = 1'b1;
    bus.wb_we_i  = 1'b0;
    bus.commit_i = 1'b0;
    bus.raddr1_i = 5'd12;
    #1;
    checks++;
    if (bus.rdata1_o !== 64'd0 || bus.retire_cnt_o !== 64'd0 || bus.last_pc_o !== 64'd0) begin
      failures++;
      $display("FAIL reset_wins x12=%h cnt=%0d pc=%h exp=0/0/0", bus.rdata1_o, bus.retire_cnt_o, bus.last_pc_o);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_write_read();
    test_bypass();
    test_x0();
    test_back_to_back();
    test_commit();
    test_ebreak();
    test_wrap();
    test_reset_wins();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
